// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset control FSM: decodes instr per state into combinational datapath controls.
// Optional macro MC_CTRL_MEM_HANDSHAKE_EN makes MEM wait for mem_ack; otherwise MEM lasts one cycle.
module mc_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ack,
    output logic        ir_wr,
    output logic        pc_wr,
    output logic [1:0]  npc_sel,
    output logic        j_sel,
    output logic        reg_wr,
    output logic [1:0]  reg_dst,
    output logic        alu_src,
    output logic [2:0]  alu_op,
    output logic [1:0]  ext_op,
    output logic [1:0]  mem_to_reg,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [2:0]  state,
    output logic        illegal,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_LUI = 3'b011;

    state_t cur;
    logic [5:0] op;
    logic [5:0] funct;
    logic is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
    logic alu_cls, mem_cls, jump_cls, known;
    logic mem_done;
    logic unused_inputs;

    assign op    = instr[31:26];
    assign funct = instr[5:0];

    assign is_addu = (op == 6'h00) && (funct == 6'h21);
    assign is_subu = (op == 6'h00) && (funct == 6'h23);
    assign is_jr   = (op == 6'h00) && (funct == 6'h08);
    assign is_ori  = (op == 6'h0D);
    assign is_lui  = (op == 6'h0F);
    assign is_lw   = (op == 6'h23);
    assign is_sw   = (op == 6'h2B);
    assign is_beq  = (op == 6'h04);
    assign is_j    = (op == 6'h02);
    assign is_jal  = (op == 6'h03);

    assign alu_cls  = is_addu | is_subu | is_ori | is_lui;
    assign mem_cls  = is_lw | is_sw;
    assign jump_cls = is_j | is_jal | is_jr;
    assign known    = alu_cls | mem_cls | jump_cls | is_beq;

`ifdef MC_CTRL_MEM_HANDSHAKE_EN
    assign mem_done = mem_ack;
`else
    assign mem_done = 1'b1;
`endif

    // zero is consumed by the fetch unit; the middle instruction fields feed the datapath only
    assign unused_inputs = ^{zero, mem_ack, instr[25:6]};

    assign state = cur;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur <= FETCH;
        end else begin
            case (cur)
                FETCH:   cur <= DECODE;
                DECODE:  cur <= (alu_cls || mem_cls || is_beq) ? EXEC : FETCH;
                EXEC:    cur <= alu_cls ? WB : (mem_cls ? MEM : FETCH);
                MEM:     if (mem_done) cur <= is_lw ? WB : FETCH;
                WB:      cur <= FETCH;
                default: cur <= FETCH;
            endcase
        end
    end

    // Every instruction (including illegal skips) raises pc_wr exactly once, so this counts retirements
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret <= 32'd0;
        end else if (pc_wr) begin
            instret <= instret + 32'd1;
        end
    end

    always_comb begin
        ir_wr      = 1'b0;
        pc_wr      = 1'b0;
        npc_sel    = 2'b00;
        j_sel      = 1'b0;
        reg_wr     = 1'b0;
        reg_dst    = 2'b00;
        alu_src    = 1'b0;
        alu_op     = ALU_ADD;
        ext_op     = 2'b00;
        mem_to_reg = 2'b00;
        mem_req    = 1'b0;
        mem_wr     = 1'b0;
        illegal    = 1'b0;

        // ALU and address operands are held from EXEC through write-back so results stay stable
        if (alu_cls && (cur == EXEC || cur == WB)) begin
            alu_src = is_ori | is_lui;
            ext_op  = is_lui ? 2'b10 : 2'b00;
            if (is_subu)     alu_op = ALU_SUB;
            else if (is_ori) alu_op = ALU_OR;
            else if (is_lui) alu_op = ALU_LUI;
            else             alu_op = ALU_ADD;
        end
        if (mem_cls && (cur == EXEC || cur == MEM || cur == WB)) begin
            alu_src = 1'b1;
            ext_op  = 2'b01;
            alu_op  = ALU_ADD;
        end

        case (cur)
            FETCH: ir_wr = 1'b1;
            DECODE: begin
                if (jump_cls) begin
                    pc_wr   = 1'b1;
                    j_sel   = is_j | is_jal;
                    npc_sel = is_jr ? 2'b11 : 2'b00;
                    if (is_jal) begin
                        reg_wr     = 1'b1;
                        reg_dst    = 2'b10;
                        mem_to_reg = 2'b10;
                    end
                end else if (!known) begin
                    illegal = 1'b1;
                    pc_wr   = 1'b1;
                end
            end
            EXEC: begin
                if (is_beq) begin
                    alu_op  = ALU_SUB;
                    pc_wr   = 1'b1;
                    npc_sel = 2'b10;
                end
            end
            MEM: begin
                mem_req = 1'b1;
                if (is_sw && mem_done) begin
                    mem_wr = 1'b1;
                    pc_wr  = 1'b1;
                end
            end
            WB: begin
                pc_wr  = 1'b1;
                reg_wr = 1'b1;
                if (is_lw) begin
                    mem_to_reg = 2'b01;
                end else begin
                    reg_dst = (op == 6'h00) ? 2'b01 : 2'b00;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed literal sequences plus randomized instructions against a path-table model.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = 32'd0;
    logic        zero = 1'b0;
    logic        mem_ack = 1'b0;
    logic        ir_wr, pc_wr, j_sel, reg_wr, alu_src, mem_req, mem_wr, illegal;
    logic [1:0]  npc_sel, reg_dst, ext_op, mem_to_reg;
    logic [2:0]  alu_op, state;
    logic [31:0] instret;

`ifdef MC_CTRL_MEM_HANDSHAKE_EN
    localparam bit HS = 1'b1;
`else
    localparam bit HS = 1'b0;
`endif

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    mc_ctrl dut (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ack(mem_ack),
        .ir_wr(ir_wr), .pc_wr(pc_wr), .npc_sel(npc_sel), .j_sel(j_sel),
        .reg_wr(reg_wr), .reg_dst(reg_dst), .alu_src(alu_src), .alu_op(alu_op),
        .ext_op(ext_op), .mem_to_reg(mem_to_reg), .mem_req(mem_req), .mem_wr(mem_wr),
        .state(state), .illegal(illegal), .instret(instret)
    );

    always #5 clk = ~clk;

    int n_compared = 0;
    int n_mismatched = 0;

    typedef enum int {C_ADDU, C_SUBU, C_JR, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_ILL} cls_t;

    typedef struct packed {
        logic       ir_wr;
        logic       pc_wr;
        logic [1:0] npc_sel;
        logic       j_sel;
        logic       reg_wr;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       mem_req;
        logic       mem_wr;
        logic       illegal;
    } exp_t;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic cls_t classify(input logic [31:0] i);
        case (i[31:26])
            6'h00: begin
                case (i[5:0])
                    6'h21:   return C_ADDU;
                    6'h23:   return C_SUBU;
                    6'h08:   return C_JR;
                    default: return C_ILL;
                endcase
            end
            6'h0D:   return C_ORI;
            6'h0F:   return C_LUI;
            6'h23:   return C_LW;
            6'h2B:   return C_SW;
            6'h04:   return C_BEQ;
            6'h02:   return C_J;
            6'h03:   return C_JAL;
            default: return C_ILL;
        endcase
    endfunction

    // Each instruction class walks a fixed list of states; F=0 D=1 E=2 M=3 W=4
    function automatic int path_len(input cls_t c);
        case (c)
            C_ADDU, C_SUBU, C_ORI, C_LUI, C_SW: return 4;
            C_LW:                               return 5;
            C_BEQ:                              return 3;
            default:                            return 2;
        endcase
    endfunction

    function automatic int path_state(input cls_t c, input int idx);
        int p[5];
        case (c)
            C_ADDU, C_SUBU, C_ORI, C_LUI: p = '{0, 1, 2, 4, 0};
            C_LW:                         p = '{0, 1, 2, 3, 4};
            C_SW:                         p = '{0, 1, 2, 3, 0};
            C_BEQ:                        p = '{0, 1, 2, 0, 0};
            default:                      p = '{0, 1, 0, 0, 0};
        endcase
        return p[idx];
    endfunction

    function automatic exp_t exp_outputs(input cls_t c, input int st, input logic dn);
        exp_t e;
        int last;
        e = '0;
        last = path_state(c, path_len(c) - 1);
        e.ir_wr   = (st == 0);
        e.pc_wr   = (st != 0) && (st == last) && (st != 3 || dn);
        e.npc_sel = (c == C_BEQ) ? 2'b10 : ((c == C_JR) ? 2'b11 : 2'b00);
        e.j_sel   = (c == C_J) || (c == C_JAL);
        e.reg_wr  = (st == 4) || (st == 1 && c == C_JAL);
        e.reg_dst = (c == C_JAL) ? 2'b10 : ((c == C_ADDU || c == C_SUBU) ? 2'b01 : 2'b00);
        e.mem_to_reg = (c == C_JAL) ? 2'b10 : ((c == C_LW) ? 2'b01 : 2'b00);
        e.mem_req = (st == 3);
        e.mem_wr  = (st == 3) && (c == C_SW) && dn;
        e.illegal = (st == 1) && (c == C_ILL);
        return e;
    endfunction

    // Reference model: position along the current instruction's path and retired count
    int          m_phase = 0;
    logic [31:0] m_instret = 32'd0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase   <= 0;
            m_instret <= 32'd0;
        end else begin
            if (path_state(classify(instr), m_phase) == 3 && HS && !mem_ack) begin
                m_phase <= m_phase;
            end else if (m_phase == path_len(classify(instr)) - 1) begin
                m_phase   <= 0;
                m_instret <= m_instret + 32'd1;
            end else begin
                m_phase <= m_phase + 1;
            end
        end
    end

    always @(negedge clk) begin : compare
        cls_t c;
        int   st;
        logic dn;
        exp_t e;
        c  = classify(instr);
        st = path_state(c, m_phase);
        dn = HS ? mem_ack : 1'b1;
        e  = exp_outputs(c, st, dn);
        checkOutput("state", 32'(state), 32'(st));
        checkOutput("instret", instret, m_instret);
        checkOutput("ir_wr", 32'(ir_wr), 32'(e.ir_wr));
        checkOutput("pc_wr", 32'(pc_wr), 32'(e.pc_wr));
        checkOutput("reg_wr", 32'(reg_wr), 32'(e.reg_wr));
        checkOutput("mem_req", 32'(mem_req), 32'(e.mem_req));
        checkOutput("mem_wr", 32'(mem_wr), 32'(e.mem_wr));
        checkOutput("illegal", 32'(illegal), 32'(e.illegal));
        if (e.pc_wr) begin
            checkOutput("npc_sel", 32'(npc_sel), 32'(e.npc_sel));
            checkOutput("j_sel", 32'(j_sel), 32'(e.j_sel));
        end
        if (e.reg_wr) begin
            checkOutput("reg_dst", 32'(reg_dst), 32'(e.reg_dst));
            checkOutput("mem_to_reg", 32'(mem_to_reg), 32'(e.mem_to_reg));
        end
        if (st == 4 && (c == C_ORI || c == C_LUI)) begin
            checkOutput("imm_alu_src", 32'(alu_src), 32'd1);
            checkOutput("imm_ext_op", 32'(ext_op), (c == C_LUI) ? 32'd2 : 32'd0);
        end
        if (st == 2 && (c == C_LW || c == C_SW)) begin
            checkOutput("addr_alu_src", 32'(alu_src), 32'd1);
            checkOutput("addr_ext_op", 32'(ext_op), 32'd1);
            checkOutput("addr_alu_op", 32'(alu_op), 32'(ALU_ADD));
        end
        if (st == 2 && c == C_BEQ) begin
            checkOutput("beq_alu_op", 32'(alu_op), 32'(ALU_SUB));
        end
    end

    logic [2:0]  s_st[8];
    logic        s_pcw[8], s_jsel[8], s_regw[8], s_ill[8], s_mreq[8];
    logic [1:0]  s_npc[8], s_rdst[8], s_m2r[8];
    logic [31:0] s_iret[8];

    task automatic doReset();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_state", 32'(state), 32'd0);
        checkOutput("rst_ir_wr", 32'(ir_wr), 32'd1);
        checkOutput("rst_instret", instret, 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    // Runs one instruction from a fresh FETCH and records outputs 1ns after each falling edge
    task automatic applyStimulus(input logic [31:0] ins, input int n, input int ack_at);
        doReset();
        instr = ins;
        zero  = 1'b1;
        for (int c = 0; c < n; c++) begin
            mem_ack = (c == ack_at);
            @(negedge clk);
            #1;
            s_st[c] = state;  s_pcw[c] = pc_wr;  s_npc[c] = npc_sel; s_jsel[c] = j_sel;
            s_regw[c] = reg_wr; s_rdst[c] = reg_dst; s_m2r[c] = mem_to_reg;
            s_ill[c] = illegal; s_mreq[c] = mem_req; s_iret[c] = instret;
            @(posedge clk);
            #2;
        end
        mem_ack = 1'b0;
    endtask

    function automatic logic [31:0] randInstr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 10))
            0: begin r[31:26] = 6'h00; r[5:0] = 6'h21; end
            1: begin r[31:26] = 6'h00; r[5:0] = 6'h23; end
            2: begin r[31:26] = 6'h00; r[5:0] = 6'h08; end
            3: r[31:26] = 6'h0D;
            4: r[31:26] = 6'h0F;
            5: r[31:26] = 6'h23;
            6: r[31:26] = 6'h2B;
            7: r[31:26] = 6'h04;
            8: r[31:26] = 6'h02;
            9: r[31:26] = 6'h03;
            default: if (classify(r) != C_ILL) r[31:26] = 6'h3F;
        endcase
        return r;
    endfunction

    initial begin
        int e_addu[5];
        int e_beq[4];
        int e_jal[3];
        int e_lw[8];
        int lw_n;
        int found;

        // addu: F D E WB F, register write with rd only in WB, one retirement
        e_addu = '{0, 1, 2, 4, 0};
        applyStimulus(32'h00221821, 5, -1);
        for (int c = 0; c < 5; c++) begin
            checkOutput($sformatf("addu_state%0d", c), 32'(s_st[c]), 32'(e_addu[c]));
            checkOutput($sformatf("addu_regwr%0d", c), 32'(s_regw[c]), (c == 3) ? 32'd1 : 32'd0);
        end
        checkOutput("addu_regdst", 32'(s_rdst[3]), 32'd1);
        checkOutput("addu_instret", s_iret[4], 32'd1);

        e_beq = '{0, 1, 2, 0};
        applyStimulus(32'h10220003, 4, -1);
        for (int c = 0; c < 4; c++) begin
            checkOutput($sformatf("beq_state%0d", c), 32'(s_st[c]), 32'(e_beq[c]));
            checkOutput($sformatf("beq_regwr%0d", c), 32'(s_regw[c]), 32'd0);
        end
        checkOutput("beq_pc_wr", 32'(s_pcw[2]), 32'd1);
        checkOutput("beq_npc_sel", 32'(s_npc[2]), 32'd2);

        e_jal = '{0, 1, 0};
        applyStimulus(32'h0C000C00, 3, -1);
        for (int c = 0; c < 3; c++)
            checkOutput($sformatf("jal_state%0d", c), 32'(s_st[c]), 32'(e_jal[c]));
        checkOutput("jal_pc_wr", 32'(s_pcw[1]), 32'd1);
        checkOutput("jal_j_sel", 32'(s_jsel[1]), 32'd1);
        checkOutput("jal_reg_wr", 32'(s_regw[1]), 32'd1);
        checkOutput("jal_reg_dst", 32'(s_rdst[1]), 32'd2);
        checkOutput("jal_mem_to_reg", 32'(s_m2r[1]), 32'd2);

        if (HS) begin
            e_lw = '{0, 1, 2, 3, 3, 3, 3, 4};
            lw_n = 8;
            applyStimulus(32'h8C220004, 8, 6);
        end else begin
            e_lw = '{0, 1, 2, 3, 4, 0, 0, 0};
            lw_n = 5;
            applyStimulus(32'h8C220004, 5, -1);
        end
        for (int c = 0; c < lw_n; c++) begin
            checkOutput($sformatf("lw_state%0d", c), 32'(s_st[c]), 32'(e_lw[c]));
            checkOutput($sformatf("lw_mem_req%0d", c), 32'(s_mreq[c]), (e_lw[c] == 3) ? 32'd1 : 32'd0);
        end
        checkOutput("lw_mem_to_reg", 32'(s_m2r[lw_n-1]), 32'd1);
        checkOutput("lw_reg_wr", 32'(s_regw[lw_n-1]), 32'd1);

        applyStimulus(32'hFC000000, 3, -1);
        checkOutput("ill_state", 32'(s_st[1]), 32'd1);
        checkOutput("ill_pulse", 32'(s_ill[1]), 32'd1);
        checkOutput("ill_after", 32'(s_ill[2]), 32'd0);
        checkOutput("ill_pc_wr", 32'(s_pcw[1]), 32'd1);
        checkOutput("ill_reg_wr", 32'(s_regw[1]), 32'd0);
        checkOutput("ill_instret", s_iret[2], 32'd1);

        // addu retires, then sw is reset while sitting in MEM
        doReset();
        instr = 32'h00221821;
        mem_ack = 1'b0;
        repeat (4) begin @(posedge clk); #2; end
        checkOutput("pre_sw_instret", instret, 32'd1);
        instr = 32'hAC220004;
        found = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #2;
            if (state == 3'd3) begin found = 1; break; end
        end
        checkOutput("sw_reach_mem", 32'(found), 32'd1);
        checkOutput("sw_instret_held", instret, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("sw_rst_state", 32'(state), 32'd0);
        checkOutput("sw_rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("sw_rst_mem_wr", 32'(mem_wr), 32'd0);
        checkOutput("sw_rst_instret", instret, 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;

        // Randomized instruction stream with occasional mid-instruction resets
        doReset();
        for (int i = 0; i < 1500; i++) begin
            if (m_phase == 0) instr = randInstr();
            mem_ack = HS ? ($urandom_range(0, 2) == 0) : $urandom_range(0, 1) == 1;
            zero    = $urandom_range(0, 1) == 1;
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 59) == 0) rst = 1'b1;
            @(posedge clk);
            #2;
        end
        rst = 1'b0;
        @(posedge clk);
        #2;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
